// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of dmem_arbiter.
// The slave modport is the arbiter; the master modport is its environment
// (the two requesters plus the data memory).
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage (port 0) and
// the loader/DMA engine (port 1). Port 0 is preferred; a starvation counter
// hands port 1 the memory after STARVE_LIMIT consecutive lost contentions.
// Read data returns one cycle after the grant and is routed to the issuer.
module dmem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]    starve_cnt;
    logic          rsp_valid;
    logic          rsp_id;
    logic          gnt0;
    logic          gnt1;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          rvalid0;
    logic          rvalid1;

    // Grant selection: port 0 preferred unless port 1 has starved long enough.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (bus.m0_req && bus.m1_req) begin
                if (starve_cnt >= LIMIT) gnt1 = 1'b1;
                else                     gnt0 = 1'b1;
            end else if (bus.m0_req) begin
                gnt0 = 1'b1;
            end else if (bus.m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Route the winner's command onto the memory port; idle drives zeros.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt0) begin
            sel_we    = bus.m0_we;
            sel_addr  = bus.m0_addr;
            sel_wdata = bus.m0_wdata;
        end else if (gnt1) begin
            sel_we    = bus.m1_we;
            sel_addr  = bus.m1_addr;
            sel_wdata = bus.m1_wdata;
        end
    end

    // Drive memory strobes, grants and the routed read response.
    always_comb begin
        bus.m0_gnt    = gnt0;
        bus.m1_gnt    = gnt1;
        bus.mem_write = (gnt0 | gnt1) & sel_we;
        bus.mem_read  = (gnt0 | gnt1) & ~sel_we;
        bus.mem_addr  = sel_addr;
        bus.mem_wdata = sel_wdata;
        // Gated by rst so a read in flight when reset arrives is dropped.
        rvalid0       = ~rst & rsp_valid & ~rsp_id;
        rvalid1       = ~rst & rsp_valid & rsp_id;
        bus.m0_rvalid = rvalid0;
        bus.m1_rvalid = rvalid1;
        bus.m0_rdata  = rvalid0 ? bus.mem_rdata : '0;
        bus.m1_rdata  = rvalid1 ? bus.mem_rdata : '0;
    end

    // Starvation counter and outstanding-read tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            if (!bus.m1_req || gnt1) begin
                starve_cnt <= '0;
            end else if (gnt0 && (starve_cnt < LIMIT)) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
            rsp_valid <= (gnt0 | gnt1) & ~sel_we;
            rsp_id    <= gnt1;
        end
    end
endmodule
